// File: rtl/multi_timer.sv
// N-channel tick timer: one shared prescaler feeds independent IDLE/RUN/DONE channels.
// Optional sticky interrupt per channel when MULTI_TIMER_STICKY_IRQ_EN is defined.
module multi_timer #(
  parameter int unsigned N_CHANNELS  = 4,
  parameter int unsigned TIMER_WIDTH = 16,
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned TICK_HZ     = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_CHANNELS-1:0]           i_start,
  input  logic [N_CHANNELS-1:0]           i_stop,
  input  logic [N_CHANNELS-1:0]           i_clear,
  input  logic [N_CHANNELS-1:0]           i_periodic,
  input  logic [N_CHANNELS*TIMER_WIDTH-1:0] i_limit,
`ifdef MULTI_TIMER_STICKY_IRQ_EN
  input  logic [N_CHANNELS-1:0]           i_irq_ack,
  output logic [N_CHANNELS-1:0]           o_irq,
`endif
  output logic                            o_tick,
  output logic [N_CHANNELS*TIMER_WIDTH-1:0] o_count,
  output logic [N_CHANNELS-1:0]           o_running,
  output logic [N_CHANNELS-1:0]           o_done,
  output logic [N_CHANNELS-1:0]           o_expire
);

  localparam int unsigned DIV   = (TICK_HZ != 0) ? CLK_FREQ / TICK_HZ : 0;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  if ((TICK_HZ == 0) || (DIV == 0) || (DIV * TICK_HZ != CLK_FREQ) || (N_CHANNELS < 1))
  begin : g_bad_cfg
    $error("multi_timer: CLK_FREQ/TICK_HZ must be an integer >= 1 and N_CHANNELS >= 1");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;

  assign tick   = (pre_cnt == PRE_W'(DIV - 1));
  assign o_tick = tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  for (genvar k = 0; k < N_CHANNELS; k++) begin : g_ch
    state_e                 state, state_nx;
    logic [TIMER_WIDTH-1:0] count, count_nx, limit, limit_nx;
    logic                   periodic, periodic_nx;
    logic                   expire, expire_nx;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state    <= IDLE;
        count    <= '0;
        limit    <= '0;
        periodic <= 1'b0;
        expire   <= 1'b0;
      end else begin
        state    <= state_nx;
        count    <= count_nx;
        limit    <= limit_nx;
        periodic <= periodic_nx;
        expire   <= expire_nx;
      end
    end

    // Priority: clear > start > stop > tick; start also discards a coincident tick.
    always_comb begin
      state_nx    = state;
      count_nx    = count;
      limit_nx    = limit;
      periodic_nx = periodic;
      expire_nx   = 1'b0;
      if (i_clear[k]) begin
        state_nx = IDLE;
        count_nx = '0;
      end else if (i_start[k]) begin
        state_nx    = RUN;
        count_nx    = '0;
        limit_nx    = i_limit[k*TIMER_WIDTH +: TIMER_WIDTH];
        periodic_nx = i_periodic[k];
      end else if (i_stop[k]) begin
        if (state == RUN) state_nx = IDLE;
      end else if (tick && (state == RUN)) begin
        if (count == limit) begin
          expire_nx = 1'b1;
          if (periodic) count_nx = '0;
          else          state_nx = DONE;
        end else begin
          count_nx = count + 1'b1;
        end
      end
    end

    assign o_count[k*TIMER_WIDTH +: TIMER_WIDTH] = count;
    assign o_running[k] = (state == RUN);
    assign o_done[k]    = (state == DONE);
    assign o_expire[k]  = expire;

`ifdef MULTI_TIMER_STICKY_IRQ_EN
    // Set off expire_nx so o_irq rises together with o_expire; set beats ack.
    logic irq;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        irq <= 1'b0;
      else if (expire_nx)                irq <= 1'b1;
      else if (i_clear[k] || i_irq_ack[k]) irq <= 1'b0;
    end
    assign o_irq[k] = irq;
`endif
  end

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer (DIV=4, 4-bit counters); expiry pulses checked via a scoreboard queue.
module tb_multi_timer;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   i_start, i_stop, i_clear, i_periodic;
  logic [N*W-1:0] i_limit;
  logic           o_tick;
  logic [N*W-1:0] o_count;
  logic [N-1:0]   o_running, o_done, o_expire;
`ifdef MULTI_TIMER_STICKY_IRQ_EN
  logic [N-1:0]   i_irq_ack;
  logic [N-1:0]   o_irq;
`endif

  multi_timer #(
    .N_CHANNELS (N),
    .TIMER_WIDTH(W),
    .CLK_FREQ   (8),
    .TICK_HZ    (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (i_start),
    .i_stop    (i_stop),
    .i_clear   (i_clear),
    .i_periodic(i_periodic),
    .i_limit   (i_limit),
`ifdef MULTI_TIMER_STICKY_IRQ_EN
    .i_irq_ack (i_irq_ack),
    .o_irq     (o_irq),
`endif
    .o_tick    (o_tick),
    .o_count   (o_count),
    .o_running (o_running),
    .o_done    (o_done),
    .o_expire  (o_expire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc = number of rising edges since reset release
  int cyc = 0;
  always @(posedge clk) if (rst_n) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct { int ch; int at; } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [W-1:0] cnt(input int k);
    return o_count[k*W +: W];
  endfunction

  task automatic set_lim(input int k, input logic [W-1:0] v);
    i_limit[k*W +: W] = v;
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: tick phase every cycle, and every expiry pulse against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("tick", o_tick, (cyc % 4) == 3);
      for (int k = 0; k < N; k++) begin
        if (o_expire[k]) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL expire_unexpected ch=%0d cyc=%0d got=1 want=0", k, cyc);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("expire_ch", k, e.ch);
            chk("expire_cyc", cyc, e.at);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    i_start = '0; i_stop = '0; i_clear = '0; i_periodic = '0; i_limit = '0;
`ifdef MULTI_TIMER_STICKY_IRQ_EN
    i_irq_ack = '0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_count", o_count, 0);
    chk("rst_running", o_running, 0);
    chk("rst_done", o_done, 0);
    chk("rst_expire", o_expire, 0);
`ifdef MULTI_TIMER_STICKY_IRQ_EN
    chk("rst_irq", o_irq, 0);
`endif
    goto(3);
    chk("idle_count", o_count, 0);

    // ch0 one-shot, limit 2: ticks at 7,11,15 -> expiry seen at 16
    goto(4);  set_lim(0, 2); i_periodic[0] = 1'b0; i_start[0] = 1'b1;
    sb.push_back('{0, 16});
    goto(5);  i_start = '0;
    chk("c0_run", o_running[0], 1);
    chk("c0_cnt0", cnt(0), 0);
    goto(8);  chk("c0_cnt1", cnt(0), 1);
    goto(12); chk("c0_cnt2", cnt(0), 2); chk("c0_run2", o_running[0], 1);
    goto(16); chk("c0_done", o_done[0], 1); chk("c0_notrun", o_running[0], 0); chk("c0_hold", cnt(0), 2);
`ifdef MULTI_TIMER_STICKY_IRQ_EN
    chk("irq0_set", o_irq[0], 1);
    goto(26); chk("irq0_sticky", o_irq[0], 1);
`endif
    goto(96); chk("c0_hold20", cnt(0), 2); chk("c0_done20", o_done[0], 1);

    // ch1 periodic, limit 0: expiry every tick; stop on a tick cycle suppresses it
    goto(100); set_lim(1, 0); i_periodic[1] = 1'b1; i_start[1] = 1'b1;
    sb.push_back('{1, 104}); sb.push_back('{1, 108}); sb.push_back('{1, 112});
    goto(101); i_start = '0;
    goto(110); chk("c1_cnt", cnt(1), 0); chk("c1_run", o_running[1], 1);
    goto(115); i_stop[1] = 1'b1;
    goto(116); i_stop = '0;
    chk("c1_stopped", o_running[1], 0); chk("c1_cnt_stop", cnt(1), 0);
    goto(130);

    // ch2: clear+start together -> clear wins; start on a tick cycle -> tick ignored
    goto(132); set_lim(2, 15); i_periodic[2] = 1'b0; i_start[2] = 1'b1;
    goto(133); i_start = '0;
    goto(152); chk("c2_cnt5", cnt(2), 5);
    goto(153); i_clear[2] = 1'b1; i_start[2] = 1'b1;
    goto(154); i_clear = '0; i_start = '0;
    chk("c2_clr_run", o_running[2], 0); chk("c2_clr_cnt", cnt(2), 0);
    goto(155); i_start[2] = 1'b1;
    goto(156); i_start = '0;
    chk("c2_st_tick_cnt", cnt(2), 0); chk("c2_st_tick_run", o_running[2], 1);
    goto(160); chk("c2_cnt1", cnt(2), 1);
    goto(163); i_start[2] = 1'b1;
    goto(164); i_start = '0; chk("c2_restart", cnt(2), 0);
    goto(165); i_clear[2] = 1'b1;
    goto(166); i_clear = '0; chk("c2_idle", o_running[2], 0);

    // ch0 restarted periodic, limit 15 (max); later limit/mode edits must be ignored
    goto(168); set_lim(0, 15); i_periodic[0] = 1'b1; i_start[0] = 1'b1;
    sb.push_back('{0, 232});
    goto(169); i_start = '0;
    chk("c0p_run", o_running[0], 1); chk("c0p_notdone", o_done[0], 0); chk("c0p_cnt0", cnt(0), 0);
    goto(180); set_lim(0, 3); i_periodic[0] = 1'b0;
    goto(200); chk("c0p_cnt8", cnt(0), 8);
    goto(228); chk("c0p_cnt15", cnt(0), 15);
    goto(232); chk("c0p_wrap", cnt(0), 0); chk("c0p_still_run", o_running[0], 1);
    goto(240); chk("c0p_cnt2", cnt(0), 2); i_stop[0] = 1'b1;
    goto(241); i_stop = '0;
    goto(244); chk("c0p_held", cnt(0), 2); chk("c0p_stopped", o_running[0], 0);
    chk("c3_cnt", cnt(3), 0); chk("c3_run", o_running[3], 0);

    // ch1 periodic, limit 3: expiries at 268 and 284
`ifdef MULTI_TIMER_STICKY_IRQ_EN
    goto(250); i_irq_ack = '1;
    goto(251); i_irq_ack = '0; chk("irq_acked", o_irq, 0);
`endif
    goto(252); set_lim(1, 3); i_periodic[1] = 1'b1; i_start[1] = 1'b1;
    sb.push_back('{1, 268}); sb.push_back('{1, 284});
    goto(253); i_start = '0;
`ifdef MULTI_TIMER_STICKY_IRQ_EN
    goto(267); chk("irq1_pre", o_irq[1], 0);
    goto(268); chk("irq1_set", o_irq[1], 1);
    goto(278); chk("irq1_sticky", o_irq[1], 1);
    goto(283); i_irq_ack[1] = 1'b1;
    goto(284); i_irq_ack = '0; chk("irq1_set_wins", o_irq[1], 1);
`endif
    goto(285); i_stop[1] = 1'b1;
    goto(286); i_stop = '0;
`ifdef MULTI_TIMER_STICKY_IRQ_EN
    i_irq_ack[1] = 1'b1;
    goto(287); i_irq_ack = '0; chk("irq1_ack", o_irq[1], 0);
`endif
    goto(288); chk("c1_final_stop", o_running[1], 0);

    goto(300);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
Parametrised successor to the single free-running seconds timer. Provides N independent channels sharing one prescaler that divides the system clock into a tick. Each channel counts ticks up to a programmable limit, in one-shot or periodic mode, and emits an expiry pulse. Sits beside the game/control FSMs as their shared timebase and timeout source.

Parameters:
N_CHANNELS, 4, number of independent timer channels (>=1)
TIMER_WIDTH, 16, per-channel counter and limit width
CLK_FREQ, 100_000_000, system clock frequency in Hz
TICK_HZ, 1, tick rate in Hz; DIV = CLK_FREQ/TICK_HZ, integer, DIV >= 1 (elaboration error otherwise)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
i_start  input  N_CHANNELS  per-channel start/restart strobe
i_stop  input  N_CHANNELS  per-channel stop strobe
i_clear  input  N_CHANNELS  per-channel clear strobe
i_periodic  input  N_CHANNELS  mode sampled on start: 1 periodic, 0 one-shot
i_limit  input  N_CHANNELS*TIMER_WIDTH  limit sampled on start; channel k at [k*TIMER_WIDTH +: TIMER_WIDTH]
o_tick  output  1  prescaler tick, one cycle high every DIV cycles
o_count  output  N_CHANNELS*TIMER_WIDTH  current channel counts, same packing as i_limit
o_running  output  N_CHANNELS  channel in RUN
o_done  output  N_CHANNELS  one-shot channel in DONE
o_expire  output  N_CHANNELS  one-cycle expiry pulse

Behaviour:
- Reset (async, rst_n low): prescaler 0, every channel IDLE, count 0, latched limit 0, mode one-shot; o_tick, o_running, o_done, o_expire all 0.
- Prescaler: counter 0..DIV-1, free-running from reset, never cleared by channel controls. o_tick = (pre_cnt == DIV-1). DIV=1: o_tick constantly 1.
- Channel FSM states: IDLE, RUN, DONE. o_running = (state==RUN), o_done = (state==DONE); both derived from state register.
- Per-channel priority in a cycle: clear > start > stop > tick. Channels fully independent.
- clear (any state): count<=0, state<=IDLE, no expiry.
- start (any state): count<=0, latch i_limit and i_periodic, state<=RUN. Start in RUN is a restart; a tick in the same cycle is ignored.
- stop: RUN->IDLE, count held; IDLE/DONE unchanged. Re-start counts from 0 (no resume).
- Tick while RUN: if count == latched limit: expiry; periodic -> count<=0, stay RUN; one-shot -> state<=DONE, count held at limit. Otherwise count<=count+1.
- Period = (limit+1) ticks; limit 0 expires on every tick.
- Limit all-ones in periodic mode: counter reaches max then returns to 0; no overflow beyond limit possible.
- o_expire: registered, high exactly one cycle, the cycle after the expiring tick edge. Clear/start in that cycle does not cancel an already-registered pulse.
- i_limit / i_periodic changes while RUN have no effect until next start.

Optional Feature:
Macro MULTI_TIMER_STICKY_IRQ_EN. Defined: adds input i_irq_ack[N_CHANNELS] and output o_irq[N_CHANNELS]; o_irq[k] sets on the cycle o_expire[k] rises, stays set until i_irq_ack[k]; simultaneous set and ack -> set wins; reset 0; i_clear[k] also clears o_irq[k]. Not defined: ports absent, no extra logic; o_expire is the only expiry indication.

Test Plan:
- CLK_FREQ=8, TICK_HZ=2 (DIV=4), after reset release -> o_tick high on cycles 3,7,11...; all outputs 0 until first start.
- Ch0 one-shot limit 2, start -> count 0,1,2 on successive ticks; o_expire[0] one cycle after 3rd tick; o_done[0]=1, count holds 2 for 20 further ticks.
- Ch1 periodic limit 0 -> o_expire[1] pulses once per tick (every 4 cycles), count stays 0; stop -> pulses cease, o_running[1]=0.
- Ch2 running, count 5: assert i_clear and i_start same cycle -> IDLE, count 0, no expiry; then start alone with tick same cycle -> count 0, RUN.
- TIMER_WIDTH=4, periodic limit 15 -> count 0..15, expiry, back to 0; ch3 idle meanwhile stays 0 (independence).
- With MULTI_TIMER_STICKY_IRQ_EN: expire ch0, o_irq[0] stays 1 for 10 cycles; ack coinciding with next expiry -> o_irq[0] remains 1; lone ack -> 0 next cycle.
